// File: rtl/r22_cplx_alu_pkg.sv
// r22_cplx_alu_pkg: shared op encoding and default widths for the R2²SDF complex ALU
package R22SdfDefinesPkg;
  typedef enum logic [1:0] {R22_MUL, R22_ADD, R22_SUB, R22_MULC} r22_op_e;
  localparam int R22_DW = 16;
  localparam int R22_TW = 16;
endpackage

// File: rtl/r22_cplx_alu_sat_round.sv
// r22_sat_round: shift, optional round-half-up (R22_CPLX_ROUND_EN), saturate IW->OW
module r22_sat_round #(
  parameter int IW = 33,
  parameter int OW = 16
) (
  input  logic [IW-1:0] x,
  input  logic [7:0]    shift,
  output logic [OW-1:0] y,
  output logic          sat
);
  localparam logic signed [IW:0] HI = {{(IW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW:0] LO = {{(IW-OW+2){1'b1}}, {(OW-1){1'b0}}};
  logic signed [IW:0] xr, ys;
`ifdef R22_CPLX_ROUND_EN
  logic [IW:0] half;
`endif
  // widen by one bit so the rounding offset cannot wrap, then shift and clamp
  always_comb begin
`ifdef R22_CPLX_ROUND_EN
    half = (shift == 8'd0) ? '0 : ((IW+1)'(1) << (shift - 8'd1));
    xr = $signed({x[IW-1], x}) + $signed(half);
`else
    xr = $signed({x[IW-1], x});
`endif
    ys = xr >>> shift;
    sat = (ys > HI) || (ys < LO);
    y = (ys < LO) ? LO[OW-1:0] : (ys > HI) ? HI[OW-1:0] : ys[OW-1:0];
  end
endmodule

// File: rtl/r22_cplx_alu.sv
// r22_cplx_alu: 3-stage complex MUL/MULC/ADD/SUB with round/saturate; R22_CPLX_ROUND_EN selects rounding
module r22_cplx_alu
  import R22SdfDefinesPkg::*;
#(
  parameter int DW   = R22_DW,
  parameter int TW   = R22_TW,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            sc,
  input  logic [DW-1:0]   a_re,
  input  logic [DW-1:0]   a_im,
  input  logic [DW-1:0]   b_re,
  input  logic [DW-1:0]   b_im,
  input  logic [TW-1:0]   w_re,
  input  logic [TW-1:0]   w_im,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   y_re,
  output logic [DW-1:0]   y_im,
  output logic            ovf,
  output logic [TAGW-1:0] out_tag
);
  localparam int PW = DW + TW;
  localparam int SW = PW + 1;
  logic en, is_mul;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  r22_op_e op1_q, op1_d, op2_q, op2_d;
  logic sc1_q, sc1_d, sc2_q, sc2_d;
  logic [TAGW-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic signed [PW-1:0] rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
  logic signed [SW-1:0] re2_q, re2_d, im2_q, im2_d;
  logic [DW-1:0] y_re_q, y_re_d, y_im_q, y_im_d, sr_re, sr_im;
  logic ovf_q, ovf_d, sat_re, sat_im;
  logic [7:0] shift;
  assign en = !v3_q || out_ready;
  assign in_ready = en;
  assign out_valid = v3_q;
  assign y_re = y_re_q;
  assign y_im = y_im_q;
  assign ovf = ovf_q;
  assign out_tag = tag3_q;
  // stage 1: partial products for MUL/MULC; ADD/SUB park a in rr/ii and b in ri/ir
  always_comb begin
    is_mul = (op == R22_MUL) || (op == R22_MULC);
    v1_d = in_valid;
    op1_d = r22_op_e'(op);
    sc1_d = sc;
    tag1_d = in_tag;
    rr_d = is_mul ? PW'($signed(a_re)) * PW'($signed(w_re)) : PW'($signed(a_re));
    ii_d = is_mul ? PW'($signed(a_im)) * PW'($signed(w_im)) : PW'($signed(a_im));
    ri_d = is_mul ? PW'($signed(a_re)) * PW'($signed(w_im)) : PW'($signed(b_re));
    ir_d = is_mul ? PW'($signed(a_im)) * PW'($signed(w_re)) : PW'($signed(b_im));
  end
  // stage 2: full-precision combine of the stage-1 terms
  always_comb begin
    v2_d = v1_q;
    op2_d = op1_q;
    sc2_d = sc1_q;
    tag2_d = tag1_q;
    re2_d = (op1_q == R22_MUL)  ? SW'(rr_q) - SW'(ii_q) :
            (op1_q == R22_MULC) ? SW'(rr_q) + SW'(ii_q) :
            (op1_q == R22_ADD)  ? SW'(rr_q) + SW'(ri_q) : SW'(rr_q) - SW'(ri_q);
    im2_d = (op1_q == R22_MUL)  ? SW'(ri_q) + SW'(ir_q) :
            (op1_q == R22_MULC) ? SW'(ir_q) - SW'(ri_q) :
            (op1_q == R22_ADD)  ? SW'(ii_q) + SW'(ir_q) : SW'(ii_q) - SW'(ir_q);
  end
  // stage 3: products drop TW-1 fraction bits, sums drop sc bits
  always_comb begin
    shift = ((op2_q == R22_MUL) || (op2_q == R22_MULC)) ? 8'(TW - 1) : {7'd0, sc2_q};
    v3_d = v2_q;
    tag3_d = tag2_q;
    y_re_d = sr_re;
    y_im_d = sr_im;
    ovf_d = sat_re || sat_im;
  end
  r22_sat_round #(.IW(SW), .OW(DW)) u_sr_re (.x(re2_q), .shift(shift), .y(sr_re), .sat(sat_re));
  r22_sat_round #(.IW(SW), .OW(DW)) u_sr_im (.x(im2_q), .shift(shift), .y(sr_im), .sat(sat_im));
  // all stages advance together on en and hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      op1_q <= R22_MUL; op2_q <= R22_MUL;
      sc1_q <= 1'b0; sc2_q <= 1'b0;
      tag1_q <= '0; tag2_q <= '0; tag3_q <= '0;
      rr_q <= '0; ii_q <= '0; ri_q <= '0; ir_q <= '0;
      re2_q <= '0; im2_q <= '0;
      y_re_q <= '0; y_im_q <= '0; ovf_q <= 1'b0;
    end else if (en) begin
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
      op1_q <= op1_d; op2_q <= op2_d;
      sc1_q <= sc1_d; sc2_q <= sc2_d;
      tag1_q <= tag1_d; tag2_q <= tag2_d; tag3_q <= tag3_d;
      rr_q <= rr_d; ii_q <= ii_d; ri_q <= ri_d; ir_q <= ir_d;
      re2_q <= re2_d; im2_q <= im2_d;
      y_re_q <= y_re_d; y_im_q <= y_im_d; ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_r22_cplx_alu.sv
// tb_r22_cplx_alu: directed self-checking bench for r22_cplx_alu (DW=TW=16)
module tb_r22_cplx_alu;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sc = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, ovf;
  logic [1:0] op = 2'd0;
  logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
  logic [15:0] y_re, y_im;
  logic [3:0] in_tag = '0, out_tag;
  int tests = 0, failed = 0;
  int sent, recv;
  logic stall, acc_in, acc_out;
  logic [15:0] sre;
  logic [3:0] stag;
  logic [3:0] pat = 4'b1001;
  int r1, r2, s1, s2;

  r22_cplx_alu #(.DW(16), .TW(16), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .sc(sc),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .y_re(y_re), .y_im(y_im), .ovf(ovf), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", t, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int o, input int s, input int ar, input int ai, input int br,
                       input int bi, input int wr, input int wi, input int tg);
    op = 2'(o); sc = 1'(s);
    a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
    w_re = 16'(wr); w_im = 16'(wi); in_tag = 4'(tg);
  endtask

  task automatic run1(input string t, input int o, input int s, input int ar, input int ai,
                      input int br, input int bi, input int wr, input int wi,
                      input int er, input int ei, input int eo);
    drive(o, s, ar, ai, br, bi, wr, wi, o + 2 * s + 3);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk({t, ".lat1"}, out_valid, 0);
    tick;
    chk({t, ".lat2"}, out_valid, 0);
    tick;
    chk({t, ".valid"}, out_valid, 1);
    chk({t, ".re"}, $signed(y_re), er);
    chk({t, ".im"}, $signed(y_im), ei);
    chk({t, ".ovf"}, ovf, eo);
    chk({t, ".tag"}, out_tag, o + 2 * s + 3);
    tick;
    chk({t, ".drain"}, out_valid, 0);
  endtask

  initial begin
`ifdef R22_CPLX_ROUND_EN
    r1 = 1; r2 = 0; s1 = 2; s2 = -2;
`else
    r1 = 0; r2 = -1; s1 = 1; s2 = -3;
`endif
    #12;
    chk("rst.valid", out_valid, 0);
    chk("rst.y_re", $signed(y_re), 0);
    chk("rst.y_im", $signed(y_im), 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.tag", out_tag, 0);
    chk("rst.in_ready", in_ready, 1);
    rst = 1'b0;
    tick;
    run1("mul_basic", 0, 0, 16384, 0, 0, 0, 16384, 0, 8192, 0, 0);
    run1("mul_jj", 0, 0, 0, 16384, 0, 0, 0, 16384, -8192, 0, 0);
    run1("mulc_jj", 3, 0, 0, 16384, 0, 0, 0, 16384, 8192, 0, 0);
    run1("mul_cross", 0, 0, 16384, 16384, 0, 0, 0, 16384, -8192, 8192, 0);
    run1("mulc_cross", 3, 0, 16384, 16384, 0, 0, 0, 16384, 8192, -8192, 0);
    run1("mul_sat", 0, 0, -32768, 0, 0, 0, -32768, 0, 32767, 0, 1);
    run1("add_sat", 1, 0, 32767, 32767, 1, 1, 0, 0, 32767, 32767, 1);
    run1("add_sc", 1, 1, 32767, 32767, 1, 1, 0, 0, 16384, 16384, 0);
    run1("sub", 2, 0, 100, -50, 30, 20, 0, 0, 70, -70, 0);
    run1("sub_sat", 2, 0, -32768, 0, 1, 0, 0, 0, -32768, 0, 1);
    run1("sub_sc", 2, 1, 5, -5, 2, 0, 0, 0, s1, s2, 0);
    run1("rnd_pos", 0, 0, 1, 0, 0, 0, 16384, 0, r1, 0, 0);
    run1("rnd_neg", 0, 0, -1, 0, 0, 0, 16384, 0, r2, 0, 0);
    sent = 0; recv = 0; stall = 1'b0; sre = '0; stag = '0;
    for (int c = 0; c < 80 && recv < 8; c++) begin
      if (stall) begin
        chk("bp.hold_re", $signed(y_re), $signed(sre));
        chk("bp.hold_tag", out_tag, stag);
      end
      out_ready = pat[c % 4];
      in_valid = sent < 8;
      drive(1, 0, sent * 100, sent, 1, 0, 0, 0, sent);
      #1;
      acc_in = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (out_valid && !out_ready) chk("bp.in_ready", in_ready, 0);
      if (acc_out) begin
        chk("bp.tag", out_tag, recv);
        chk("bp.re", $signed(y_re), recv * 100 + 1);
        chk("bp.im", $signed(y_im), recv);
        recv++;
      end
      stall = out_valid && !out_ready;
      sre = y_re;
      stag = out_tag;
      @(posedge clk);
      #1;
      if (acc_in) sent++;
    end
    chk("bp.count", recv, 8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp.no_dup", out_valid, 0);
    tick;
    drive(1, 0, 100, 100, 1, 1, 0, 0, 1);
    in_valid = 1'b1;
    tick;
    in_tag = 4'd2;
    tick;
    in_tag = 4'd3;
    tick;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.valid", out_valid, 0);
    chk("mid_rst.y_re", $signed(y_re), 0);
    chk("mid_rst.y_im", $signed(y_im), 0);
    chk("mid_rst.ovf", ovf, 0);
    chk("mid_rst.in_ready", in_ready, 1);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("post_rst.idle", out_valid, 0);
    end
    run1("post_rst", 1, 0, 10, 20, 3, 4, 0, 0, 13, 24, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/r22_cplx_alu.md
# r22_cplx_alu

Parametrised, pipelined complex arithmetic unit for the R2²SDF FFT datapath. It replaces the combinational complex multiply, add and subtract helpers with one registered block. The block adds these features:
- independent data and twiddle widths;
- conjugate multiply;
- rounding and saturation with an overflow flag;
- a valid/ready handshake with tag pass-through.

Butterfly stages and twiddle rotators instantiate it between SDF delay lines.

## Interface
- DW, 16, data width of a, b and result (signed Q1.DW-1)
- TW, 16, twiddle width of w (signed Q1.TW-1), 2..DW+8
- TAGW, 4, width of user tag carried alongside data
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts the beat this cycle
- op  in  2  0=MUL a·w, 1=ADD a+b, 2=SUB a−b, 3=MULC a·conj(w)
- sc  in  1  ADD/SUB only: 1 = arithmetic shift right by 1 after sum
- a_re, a_im  in  DW  operand a
- b_re, b_im  in  DW  operand b (ADD/SUB)
- w_re, w_im  in  TW  twiddle (MUL/MULC)
- in_tag  in  TAGW  user tag
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts
- y_re, y_im  out  DW  result
- ovf  out  1  saturation occurred on y_re or y_im of this beat
- out_tag  out  TAGW  tag of this beat

## Operation
- **Handshake.** A beat transfers when in_valid && in_ready; the result transfers when out_valid && out_ready.
- **Stall.** en = !out_valid || out_ready, and in_ready = en. All three stages advance together when en=1 and hold otherwise. Bubbles advance only with the pipeline; they are never compressed.
- **Stage 1.** Register op, sc and tag.
  - MUL/MULC: register the four partial products a_re·w_re, a_im·w_im, a_re·w_im and a_im·w_re, each DW+TW bits.
  - ADD/SUB: register a and b.
- **Stage 2.** Form the full-precision sums (DW+TW+1 bits).
  - MUL: re = rr − ii, im = ri + ir.
  - MULC: re = rr + ii, im = ir − ri.
  - ADD/SUB: sum/difference at DW+1 bits, sign-extended.
- **Stage 3.** Round, shift, saturate, then drive y, ovf and out_tag.
  - MUL/MULC: shift = TW−1.
  - ADD/SUB: shift = sc.
  - Saturation: clamp to [−2^(DW−1), 2^(DW−1)−1]; ovf = clamp active on either component.
- **Rounding** is per the configuration macro below. For ADD/SUB with sc=0 the shift is zero and rounding is a no-op.
- **Corner case.** (−1)·(−1) in MUL saturates to 2^(DW−1)−1 with ovf=1.

## Timing
- Latency: 3 enabled cycles from input transfer to out_valid. Throughput: 1 beat/cycle while out_ready=1.
- Reset values: out_valid=0, y_re=y_im=0, ovf=0, out_tag=0, in_ready=1, and all internal stage valid bits 0.
- Reset mid-operation: all in-flight beats are discarded and no spurious out_valid is produced after release.
- Backpressure with out_ready=0 while out_valid=1: y, ovf and out_tag hold stable and in_ready=0 in the same cycle.
- Simultaneous input and output transfer in one cycle is legal and loses no beats.
- Op may change every beat; each stage uses its own registered op.

## Configuration
- **R22_CPLX_ROUND_EN defined:** round-half-up. Add 2^(shift−1) before the arithmetic shift when shift>0.
- **R22_CPLX_ROUND_EN undefined:** truncation (floor, plain >>>), bit-exact with the legacy cmul/cadd/csub behaviour apart from saturation.
- Latency is identical in both builds.

## Structure
- **Shared package R22SdfDefinesPkg:**
  - enum r22_op_e (R22_MUL, R22_ADD, R22_SUB, R22_MULC);
  - default localparams DW=16 and TW=16.
  - The parametrised widths stay module parameters, because package structs cannot be parametrised.
- **Sub-module r22_sat_round:** combinational, parameters IW/OW. It takes an IW-bit value and a shift amount and returns the OW-bit result plus a sat flag. It is instantiated twice in stage 3, once each for re and im.

## Test plan
All values use DW=TW=16.
- **MUL basic:** a=(16384,0), w=(16384,0), op=0 -> y=(8192,0), ovf=0, exactly 3 cycles later.
- **MUL vs MULC:** a=(0,16384), w=(0,16384).
  - op=0 -> y=(−8192,0).
  - op=3 -> y=(8192,0).
- **Saturation:**
  - MUL a=(−32768,0), w=(−32768,0) -> y_re=32767, ovf=1.
  - ADD a=(32767,32767), b=(1,1), sc=0 -> y=(32767,32767), ovf=1.
  - Same ADD with sc=1 -> (16384,16384), ovf=0.
- **Rounding:** MUL a=(1,0),(−1,0), w=(16384,0).
  - ROUND_EN build -> y_re=1, then 0.
  - Without ROUND_EN -> y_re=0, then −1.
- **Backpressure:** 8 back-to-back beats with tags 0..7 while out_ready toggles 1,0,0,1,… -> all 8 results emerge in order with matching tags, none lost or duplicated, and y is stable while stalled.
- **Reset:** assert rst with 3 beats in flight -> out_valid=0, y=0, ovf=0. No output appears until new input.
